// File: rtl/line_mem_responder.sv
// Line-granular slow memory: accepts one whole-line read or write, waits a fixed
// latency, commits/loads the line and answers with a single-cycle gnt pulse.

module line_mem_bank #(
  parameter int ADDR_LEN = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata
);
  // Storage is never reset; it only starts out zeroed.
  logic [31:0] mem [2**ADDR_LEN] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

module line_mem_responder #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 10,
  parameter int RD_LATENCY    = 50,
  parameter int WR_LATENCY    = 50
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [ADDR_LEN-1:0]                  addr,
  input  logic                                 rd_req,
  input  logic                                 wr_req,
  input  logic [(2**LINE_ADDR_LEN)-1:0][31:0]  wr_line,
  output logic [(2**LINE_ADDR_LEN)-1:0][31:0]  rd_line,
  output logic                                 gnt
);
  localparam int LINE_SIZE = 2**LINE_ADDR_LEN;
  localparam int MAX_LAT   = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W     = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] RD_LD = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LD = CNT_W'(WR_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  typedef struct packed {
    logic [ADDR_LEN-1:0]        addr;
    logic [LINE_SIZE-1:0][31:0] line;
  } req_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q;
  logic             accept;
  logic             commit_wr, commit_rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_q.addr <= addr;
        if (wr_req) req_q.line <= wr_line;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    commit_wr = 1'b0;
    commit_rd = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_req || rd_req) begin
          accept  = 1'b1;
          state_d = wr_req ? WR_WAIT : RD_WAIT;
          cnt_d   = wr_req ? WR_LD : RD_LD;
        end
      end
      RD_WAIT: begin
        if (!rd_req)            state_d = IDLE;
        else if (cnt_q == '0) begin
          state_d   = DONE;
          commit_rd = 1'b1;
        end else                cnt_d = cnt_q - CNT_W'(1);
      end
      WR_WAIT: begin
        if (!wr_req)            state_d = IDLE;
        else if (cnt_q == '0) begin
          state_d   = DONE;
          commit_wr = 1'b1;
        end else                cnt_d = cnt_q - CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A reset edge must not let a pending write land in storage.
    if (!rst_n) begin
      commit_wr = 1'b0;
      commit_rd = 1'b0;
    end
  end

  assign gnt = (state_q == DONE);

  for (genvar w = 0; w < LINE_SIZE; w++) begin : g_bank
    line_mem_bank #(.ADDR_LEN(ADDR_LEN)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (commit_wr),
      .re    (commit_rd),
      .addr  (req_q.addr),
      .wdata (req_q.line[w]),
      .rdata (rd_line[w])
    );
  end
endmodule
